// File: rtl/motion_detect_pkg.sv
// rtl/motion_detect_pkg.sv - shared pixel/word types and geometry for the motion_detect pipeline
package motion_detect_pkg;

    typedef logic [7:0]  pixel_t;
    typedef logic [31:0] word_t;

    localparam int BYTES_PER_PIXEL = 3;
    localparam int BYTES_PER_WORD  = 4;
    localparam int BUF_BYTES       = 8;

    localparam int DEFAULT_IMG_WIDTH  = 720;
    localparam int DEFAULT_IMG_HEIGHT = 540;

endpackage

// File: rtl/rgb_to_gray.sv
// rtl/rgb_to_gray.sv - combinational B,G,R to gray as truncated (B+G+R)/3
module rgb_to_gray
    import motion_detect_pkg::*;
(
    input  pixel_t i_b,
    input  pixel_t i_g,
    input  pixel_t i_r,
    output pixel_t o_gray
);

    logic [9:0] w_sum;

    assign w_sum  = {2'b00, i_b} + {2'b00, i_g} + {2'b00, i_r};
    assign o_gray = pixel_t'(w_sum / 10'd3);

endmodule

// File: rtl/bgr_unpack_gray.sv
// rtl/bgr_unpack_gray.sv - realign 32-bit BMP words into B,G,R pixels, write 8-bit gray
// Optional PIX_COUNT_EN adds the per-frame pix_count / frame_done outputs.
module bgr_unpack_gray
    import motion_detect_pkg::*;
#(
    parameter  int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter  int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
    localparam int PC_W       = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   in_empty,
    input  word_t  in_dout,
    output logic   in_rd_en,
    input  logic   out_full,
    output logic   out_wr_en,
    output pixel_t out_din
`ifdef PIX_COUNT_EN
    ,
    output logic [PC_W-1:0] pix_count,
    output logic            frame_done
`endif
);

    localparam int BUF_W = 8 * BUF_BYTES;
    localparam int CNT_W = $clog2(BUF_BYTES + 1);

    if ((IMG_WIDTH * BYTES_PER_PIXEL) % BYTES_PER_WORD != 0 || PC_W < 1) begin : g_bad_geometry
        $error("bgr_unpack_gray: line length must be a whole number of words");
    end

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_emit;
    logic             w_pop;
    logic [CNT_W-1:0] w_cnt_kept;
    logic [CNT_W-1:0] w_cnt_next;
    logic [BUF_W-1:0] w_buf_kept;
    logic [BUF_W-1:0] w_buf_next;

    // Bytes above r_cnt are always zero, so a new word can be OR-ed in at the fill level.
    always_comb begin
        w_emit     = reset && (r_cnt >= CNT_W'(BYTES_PER_PIXEL)) && !out_full;
        w_cnt_kept = w_emit ? r_cnt - CNT_W'(BYTES_PER_PIXEL) : r_cnt;
        w_buf_kept = w_emit ? (r_buf >> (8 * BYTES_PER_PIXEL)) : r_buf;
        w_pop      = reset && !in_empty
                     && (w_cnt_kept <= CNT_W'(BUF_BYTES - BYTES_PER_WORD));
        w_buf_next = w_buf_kept;
        w_cnt_next = w_cnt_kept;
        if (w_pop) begin
            w_buf_next = w_buf_kept | (BUF_W'(in_dout) << {w_cnt_kept, 3'b000});
            w_cnt_next = w_cnt_kept + CNT_W'(BYTES_PER_WORD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign in_rd_en  = w_pop;
    assign out_wr_en = w_emit;

    rgb_to_gray u_gray (
        .i_b    (r_buf[7:0]),
        .i_g    (r_buf[15:8]),
        .i_r    (r_buf[23:16]),
        .o_gray (out_din)
    );

`ifdef PIX_COUNT_EN
    logic [PC_W-1:0] r_pix_count;

    assign pix_count  = r_pix_count;
    assign frame_done = w_emit && (r_pix_count == PC_W'(IMG_WIDTH * IMG_HEIGHT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_count <= '0;
        end else if (w_emit) begin
            r_pix_count <= frame_done ? '0 : r_pix_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bgr_unpack_gray.sv
// tb/tb_bgr_unpack_gray.sv - scoreboard bench for bgr_unpack_gray (PIX_COUNT_EN aware)
module tb_bgr_unpack_gray;

`ifdef PIX_COUNT_EN
    localparam int W = 4;
    localparam int H = 2;
    localparam int PCW = $clog2(W * H);
`else
    localparam int W = 720;
    localparam int H = 540;
`endif
    localparam int FRAME = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_empty = 1'b1;
    logic [31:0] in_dout = 32'h0;
    logic        out_full = 1'b0;
    logic        in_rd_en;
    logic        out_wr_en;
    logic [7:0]  out_din;
`ifdef PIX_COUNT_EN
    logic [PCW-1:0] pix_count;
    logic           frame_done;
`endif

    always #5 clk = ~clk;

    bgr_unpack_gray #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .in_rd_en  (in_rd_en),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .out_din   (out_din)
`ifdef PIX_COUNT_EN
        ,
        .pix_count (pix_count),
        .frame_done(frame_done)
`endif
    );

    int total = 0;
    int bad = 0;
    logic [31:0] src[$];
    logic [7:0]  mbytes[$];
    logic [7:0]  expq[$];
    int cyc = 0, pops = 0, writes = 0, nw = 0, fd_cnt = 0;
    int first_wr = -1, last_wr = -1, first_pop = -1;
    logic rd_s = 1'b0;
    logic ctl_full = 1'b0, ctl_gate = 1'b0, mode_tgl = 1'b0, mode_rand = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_raw(input logic [31:0] w);
        src.push_back(w);
    endtask

    task automatic push_model(input logic [31:0] w);
        int s;
        src.push_back(w);
        for (int b = 0; b < 4; b++) mbytes.push_back(w[8*b +: 8]);
        while (mbytes.size() >= 3) begin
            s = int'(mbytes.pop_front());
            s += int'(mbytes.pop_front());
            s += int'(mbytes.pop_front());
            expq.push_back(8'(s / 3));
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            if (src.size() == 0 && expq.size() == 0) break;
        end
        check(name, int'(i < budget), 1);
        repeat (3) @(posedge clk);
    endtask

    // Upstream FIFO / downstream flag driver, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (rd_s && src.size() > 0) void'(src.pop_front());
        if (mode_tgl) ctl_gate = ~ctl_gate;
        out_full = mode_rand ? ($urandom_range(0, 99) < 30) : ctl_full;
        in_empty = ctl_gate || (src.size() == 0);
        in_dout  = (src.size() > 0) ? src[0] : 32'h0;
    end

    // Monitor: samples mid-cycle, scores every write against the expected queue.
    always @(negedge clk) begin
        cyc++;
        rd_s = in_rd_en;
        if (!reset) nw = 0;
        if (reset && in_rd_en) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
        end
`ifdef PIX_COUNT_EN
        if (reset && frame_done && !out_wr_en) begin
            total++; bad++;
            $display("FAIL frame_done_without_write: got 1 expected 0");
        end
`endif
        if (reset && out_wr_en) begin
            writes++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got pixel %0d expected no write", out_din);
            end else begin
                check("pixel", int'(out_din), int'(expq.pop_front()));
            end
`ifdef PIX_COUNT_EN
            check("pix_count", int'(pix_count), nw % FRAME);
            check("frame_done", int'(frame_done), int'((nw % FRAME) == FRAME - 1));
            if (frame_done) fd_cnt++;
`endif
            nw++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, w0;
        // reset state, with a word waiting upstream
        push_raw(32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #2;
        check("rst_rd_en", int'(in_rd_en), 0);
        check("rst_wr_en", int'(out_wr_en), 0);
        check("rst_out_din", int'(out_din), 0);
        check("rst_cnt", int'(dut.r_cnt), 0);
        src.delete();
        @(posedge clk);
        #2 reset = 1'b1;

        // 1: three words, hand-computed pixels
        first_pop = -1; first_wr = -1; w0 = writes;
        push_raw(32'hFF5A3C1E); push_raw(32'h0000FFFF); push_raw(32'h00010103);
        expq.push_back(8'h3C); expq.push_back(8'hFF); expq.push_back(8'h01); expq.push_back(8'h00);
        wait_idle(100, "t1_drain");
        check("t1_writes", writes - w0, 4);
        check("t1_latency", first_wr - first_pop, 1);
        check("t1_cnt_end", int'(dut.r_cnt), 0);

        // 2: downstream full for 20 clocks
        ctl_full = 1'b1; p0 = pops; w0 = writes;
        for (int i = 0; i < 9; i++) push_model(32'h10203040 + 32'(i * 32'h01010101));
        repeat (20) @(posedge clk);
        #2;
        check("t2_pops_full", pops - p0, 2);
        check("t2_writes_full", writes - w0, 0);
        @(posedge clk);
        ctl_full = 1'b0; p0 = pops; w0 = writes;
        repeat (2) @(posedge clk);
        #2;
        check("t2_writes_release", writes - w0, 2);
        check("t2_pops_release", pops - p0, 1);
        wait_idle(200, "t2_drain");

        // 3: 3000 back-to-back words
        first_wr = -1; w0 = writes;
        for (int i = 0; i < 3000; i++) push_model($urandom);
        wait_idle(5000, "t3_drain");
        check("t3_writes", writes - w0, 4000);
        check("t3_continuous", last_wr - first_wr + 1, 4000);

        // 4: reset with five bytes buffered
        push_raw(32'h11223344);
        expq.push_back(8'h33);
        wait_idle(50, "t4_first");
        ctl_full = 1'b1;
        push_raw(32'h55667788);
        repeat (5) @(posedge clk);
        @(posedge clk);
        push_raw(32'h99AABBCC);
        ctl_full = 1'b0;
        #2;
        check("t4_rd_before", int'(in_rd_en), 1);
        check("t4_wr_before", int'(out_wr_en), 1);
        reset = 1'b0;
        src.delete(); mbytes.delete();
        #1;
        check("t4_rd_in_reset", int'(in_rd_en), 0);
        check("t4_wr_in_reset", int'(out_wr_en), 0);
        check("t4_out_din_reset", int'(out_din), 0);
        check("t4_exp_empty", expq.size(), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        w0 = writes;
        push_raw(32'hFF5A3C1E); push_raw(32'h0000FFFF); push_raw(32'h00010103);
        expq.push_back(8'h3C); expq.push_back(8'hFF); expq.push_back(8'h01); expq.push_back(8'h00);
        wait_idle(100, "t4_drain");
        check("t4_writes", writes - w0, 4);
        check("t4_cnt_end", int'(dut.r_cnt), 0);

        // 5: toggling empty, random full
        mode_tgl = 1'b1; mode_rand = 1'b1;
        for (int i = 0; i < 60; i++) push_model($urandom);
        wait_idle(3000, "t5_drain");
        mode_tgl = 1'b0; mode_rand = 1'b0; ctl_gate = 1'b0;
        repeat (2) @(posedge clk);

`ifdef PIX_COUNT_EN
        // 6: two 4x2 frames
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < 12; i++) push_model($urandom);
        wait_idle(200, "t6_drain");
        check("t6_frame_pulses", fd_cnt, 2);
        check("t6_pix_count_end", int'(pix_count), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
